tx_byte_queue: RTL and testbench

TX_BYTE_QUEUE -- requirements
Module: tx_byte_queue

---
 rtl/tx_byte_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_tx_byte_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_byte_queue.sv
// -----------------------------------------------------------------------------
// tx_byte_queue
//   Byte queue in front of a UART transmitter. Bytes come either from the
//   display formatter (valid/ready handshake) or, when the echo path is built
//   in and selected, from received UART bytes (strobe only, no backpressure).
//   Queued bytes are handed to the transmitter one at a time through a small
//   launch/handshake FSM: a one-cycle tx_start pulse, then wait for tx_busy to
//   rise (bounded by BUSY_TMO cycles) and fall again.
//
// Build option:
//   TXQ_ECHO_EN  - compiles in the echo path (echo_data/echo_valid/echo_mode
//                  and overflow). Without it the echo ports exist but are
//                  ignored, echo_mode reads as 0 and overflow stays 0.
//
// Parameters:
//   DEPTH     queue depth in bytes (power of two, >= 4)
//   BUSY_TMO  cycles to wait for tx_busy to rise after tx_start
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fmt_data/valid   formatter byte and valid; fmt_ready is the handshake ready
//   echo_data/valid  echo byte strobe; echo_mode selects the echo source
//   flush            synchronous queue clear (also clears overflow)
//   tx_data/tx_start byte and launch pulse to the UART transmitter
//   tx_busy          transmitter busy
//   fifo_count       number of bytes queued
//   overflow         sticky: an echo byte was dropped on a full queue
//   idle             queue empty and FSM idle
// -----------------------------------------------------------------------------
module tx_byte_queue #(
  parameter int DEPTH    = 16,
  parameter int BUSY_TMO = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 fmt_data,
  input  logic                       fmt_valid,
  output logic                       fmt_ready,
  input  logic [7:0]                 echo_data,
  input  logic                       echo_valid,
  input  logic                       echo_mode,
  input  logic                       flush,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST_C = TW'(BUSY_TMO - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            overflow_q, overflow_d;
  logic            idle_q, idle_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      mem_q [DEPTH];

  logic            echo_mode_s;
  logic            echo_valid_s;
  logic [7:0]      echo_data_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            drop_s;
  logic [7:0]      wr_data_s;

`ifdef TXQ_ECHO_EN
  assign echo_mode_s  = echo_mode;
  assign echo_valid_s = echo_valid;
  assign echo_data_s  = echo_data;
`else
  // Echo path not built: the inputs are deliberately left unconnected.
  logic unused_echo_s;
  assign unused_echo_s = ^{echo_data, echo_valid, echo_mode};
  assign echo_mode_s   = 1'b0;
  assign echo_valid_s  = 1'b0;
  assign echo_data_s   = 8'h00;
`endif

  assign full_s    = (count_q == DEPTH_C);
  // Ready is forced low during reset so nothing is handshaken before release.
  assign fmt_ready = rst_n && !full_s && !echo_mode_s && !flush;

  // Flush beats any write; a full queue never accepts, even with a pop pending.
  assign push_s    = !flush && (echo_mode_s ? (echo_valid_s && !full_s)
                                            : (fmt_valid && fmt_ready));
  assign drop_s    = !flush && echo_mode_s && echo_valid_s && full_s;
  assign pop_s     = !flush && (state_q == IDLE) && (count_q != {(AW+1){1'b0}})
                     && !tx_busy;
  assign wr_data_s = echo_mode_s ? echo_data_s : fmt_data;

  // Next-state logic for queue pointers, count, overflow and the launch FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overflow_d = overflow_q;
    tmo_d      = tmo_q;

    if (flush) begin
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {(AW+1){1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d   = LAUNCH;
          tx_data_d = mem_q[rd_ptr_q];
        end else begin
          state_d   = IDLE;
        end
      end
      LAUNCH: begin
        // tx_start is registered, so it is seen in the cycle after LAUNCH.
        state_d    = WAIT_HI;
        tx_start_d = 1'b1;
        tmo_d      = {TW{1'b0}};
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (tmo_q == TMO_LAST_C) begin
          // Transmitter never acknowledged: treat the byte as sent.
          state_d = IDLE;
        end else begin
          tmo_d   = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    idle_d = (count_d == {(AW+1){1'b0}}) && (state_d == IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
      idle_q     <= 1'b1;
      tmo_q      <= {TW{1'b0}};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
      idle_q     <= idle_d;
      tmo_q      <= tmo_d;
    end
  end

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_s;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_tx_byte_queue.sv
module tb_tx_byte_queue;

  logic       clk;
  logic       rst_n;
  logic [7:0] fmt_data;
  logic       fmt_valid;
  logic       fmt_ready;
  logic [7:0] echo_data;
  logic       echo_valid;
  logic       echo_mode;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       idle;

  logic       busy_force;
  logic       resp_en;
  int         resp_cnt;
  logic [7:0] sent_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  tx_byte_queue #(.DEPTH(16), .BUSY_TMO(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fmt_data(fmt_data), .fmt_valid(fmt_valid), .fmt_ready(fmt_ready),
    .echo_data(echo_data), .echo_valid(echo_valid), .echo_mode(echo_mode),
    .flush(flush),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART responder: raises busy the cycle after tx_start, for 10 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_cnt <= 0;
    else if (resp_en && tx_start === 1'b1) resp_cnt <= 10;
    else if (resp_cnt != 0) resp_cnt <= resp_cnt - 1;
  end
  assign tx_busy = busy_force | (resp_cnt != 0);

  // Log every launched byte.
  always @(posedge clk) begin
    if (tx_start === 1'b1) sent_q.push_back(tx_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int k;
    rst_n = 1'b0; fmt_data = 8'h00; fmt_valid = 1'b0;
    echo_data = 8'h00; echo_valid = 1'b0; echo_mode = 1'b0; flush = 1'b0;
    busy_force = 1'b0; resp_en = 1'b0;

    // Reset values
    #12;
    chk("rst_fmt_ready", fmt_ready, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_idle", idle, 1);
    step;
    rst_n = 1'b1;
    #1;
    chk("rel_fmt_ready", fmt_ready, 1);
    step;

    // Single byte, latency and busy handshake
    resp_en = 1'b1;
    fmt_data = 8'h41; fmt_valid = 1'b1;
    step;                       // push edge
    fmt_valid = 1'b0;
    chk("a_count", fifo_count, 1);
    chk("a_idle0", idle, 0);
    step;
    chk("a_start_early", tx_start, 0);
    chk("a_data_pop", tx_data, 8'h41);
    step;
    chk("a_start", tx_start, 1);
    chk("a_data", tx_data, 8'h41);
    step;
    chk("a_start_one", tx_start, 0);
    for (k = 0; k < 40 && tx_busy !== 1'b0; k++) step;
    chk("a_busy_fall_timeout", tx_busy, 0);
    step;
    chk("a_idle", idle, 1);
    chk("a_sent", sent_q.size(), 1);

    // Fill to full with busy held, then drain in order
    busy_force = 1'b1;
    base = sent_q.size();
    fmt_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fmt_data = 8'(i);
      step;
    end
    fmt_data = 8'hEE;
    chk("b_count16", fifo_count, 16);
    chk("b_ready0", fmt_ready, 0);
    step;
    fmt_valid = 1'b0;
    chk("b_full_no_push", fifo_count, 16);
    busy_force = 1'b0;
    for (k = 0; k < 600 && sent_q.size() - base < 16; k++) step;
    chk("b_sent16", sent_q.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < sent_q.size()) chk($sformatf("b_order%0d", i), sent_q[base + i], i);
    end
    for (k = 0; k < 40 && idle !== 1'b1; k++) step;
    chk("b_idle", idle, 1);
    chk("b_count0", fifo_count, 0);

    // Busy never rises: 4-cycle timeout, then next byte
    resp_en = 1'b0;
    base = sent_q.size();
    fmt_valid = 1'b1; fmt_data = 8'hA1;
    step;                       // E0
    fmt_data = 8'hA2;
    chk("c_count1", fifo_count, 1);
    step;                       // E1: push A2 and pop A1
    fmt_valid = 1'b0;
    chk("c_pushpop_count", fifo_count, 1);
    chk("c_data_a1", tx_data, 8'hA1);
    step;                       // E2
    chk("c_start1", tx_start, 1);
    repeat (5) step;            // E7
    chk("c_data_a2", tx_data, 8'hA2);
    chk("c_start_gap", tx_start, 0);
    chk("c_count0", fifo_count, 0);
    step;                       // E8
    chk("c_start2", tx_start, 1);
    for (k = 0; k < 40 && idle !== 1'b1; k++) step;
    chk("c_idle", idle, 1);
    chk("c_sent2", sent_q.size() - base, 2);

    // Reset during WAIT_LO with 3 bytes queued
    resp_en = 1'b1;
    fmt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fmt_data = 8'(8'hB0 + i);
      step;
    end
    fmt_valid = 1'b0;
    step; step;
    chk("d_count3", fifo_count, 3);
    chk("d_busy", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("d_tx_start", tx_start, 0);
    chk("d_tx_data", tx_data, 8'h00);
    chk("d_count", fifo_count, 0);
    chk("d_overflow", overflow, 0);
    chk("d_idle", idle, 1);
    chk("d_ready", fmt_ready, 0);
    step; step;
    rst_n = 1'b1;
    base = sent_q.size();
    repeat (40) step;
    chk("d_no_start", sent_q.size(), base);
    chk("d_count_after", fifo_count, 0);

    // Flush with a simultaneous push
    busy_force = 1'b1;
    fmt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fmt_data = 8'(8'hC0 + i);
      step;
    end
    chk("e_count3", fifo_count, 3);
    fmt_data = 8'h77; flush = 1'b1;
    #1;
    chk("e_ready_flush", fmt_ready, 0);
    step;
    flush = 1'b0; fmt_valid = 1'b0;
    chk("e_count0", fifo_count, 0);
    chk("e_idle", idle, 1);
    busy_force = 1'b0;
    base = sent_q.size();
    repeat (10) step;
    chk("e_no_start", sent_q.size(), base);

`ifdef TXQ_ECHO_EN
    // Echo into a full queue drops the byte and sets overflow
    busy_force = 1'b1;
    echo_mode = 1'b1;
    #1;
    chk("f_ready_echo", fmt_ready, 0);
    echo_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      echo_data = 8'(8'h30 + i);
      step;
    end
    chk("f_count16", fifo_count, 16);
    chk("f_ovf0", overflow, 0);
    echo_data = 8'h55;
    step;
    echo_valid = 1'b0;
    chk("f_ovf1", overflow, 1);
    chk("f_count_stay", fifo_count, 16);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("f_ovf_clr", overflow, 0);
    chk("f_count_clr", fifo_count, 0);
    echo_mode = 1'b0;
    busy_force = 1'b0;
`else
    // Echo path absent: echo strobes ignored, formatter still works
    busy_force = 1'b1;
    echo_mode = 1'b1; echo_data = 8'h55;
    #1;
    chk("f_ready_noecho", fmt_ready, 1);
    repeat (3) begin
      echo_valid = 1'b1; step;
      echo_valid = 1'b0; step;
    end
    chk("f_count0", fifo_count, 0);
    chk("f_ovf0", overflow, 0);
    fmt_data = 8'h5A; fmt_valid = 1'b1;
    step;
    fmt_valid = 1'b0;
    chk("f_count1", fifo_count, 1);
    base = sent_q.size();
    busy_force = 1'b0;
    for (k = 0; k < 40 && sent_q.size() == base; k++) step;
    chk("f_sent1", sent_q.size() - base, 1);
    if (sent_q.size() > base) chk("f_sent_data", sent_q[base], 8'h5A);
    echo_mode = 1'b0;
`endif

    repeat (20) step;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
